// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle through a single full-adder cell, IDLE/RUN/DONE handshake.
// Optional signed-overflow output when SERIAL_ADDER_OVERFLOW_EN is defined.

module fullAdder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_ADDER_OVERFLOW_EN
  , output logic           overflow
`endif
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] aReg, bReg, sumReg;
  logic             cReg, coReg;
  logic [IW-1:0]    bitIdx;
  logic             faSum, faCout;
  logic             accept, lastBit;

  assign accept  = in_valid && in_ready;
  assign lastBit = (bitIdx == IW'(WIDTH - 1));

  fullAdder uFa (
    .sum  (faSum),
    .cout (faCout),
    .a    (aReg[bitIdx]),
    .b    (bReg[bitIdx]),
    .cin  (cReg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = RUN;
      end
      RUN:  if (lastBit) stateNext = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Index stops at WIDTH-1 and is only cleared by the next accept, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aReg   <= '0;
      bReg   <= '0;
      cReg   <= 1'b0;
      bitIdx <= '0;
      sumReg <= '0;
      coReg  <= 1'b0;
    end else if (accept) begin
      aReg   <= a;
      bReg   <= b;
      cReg   <= carryin;
      bitIdx <= '0;
      sumReg <= '0;
    end else if (state == RUN) begin
      sumReg[bitIdx] <= faSum;
      cReg           <= faCout;
      if (lastBit) coReg  <= faCout;
      else         bitIdx <= bitIdx + 1'b1;
    end
  end

  assign sum      = sumReg;
  assign carryout = coReg;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovReg;

  // cReg is the carry into the MSB while the last bit is being processed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         ovReg <= 1'b0;
    else if (state == RUN && lastBit)     ovReg <= cReg ^ faCout;
  end

  assign overflow = ovReg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expectations, a negedge monitor pops them.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] a, b;
  logic         carryin, in_valid, out_ready;
  logic         in_ready, carryout, out_valid;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .carryin   (carryin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carryout  (carryout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops on the rising of out_valid, then checks the result is held until released.
  logic         prevOv = 1'b0;
  logic [W-1:0] heldSum;
  logic         heldCo;
  exp_t         e;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (!prevOv) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("carryout", 32'(carryout), 32'(e.co));
          chk("latency", 32'(cyc - e.acc), 32'(W));
`ifdef SERIAL_ADDER_OVERFLOW_EN
          chk("overflow", 32'(overflow), 32'(e.ov));
`endif
        end
        heldSum <= sum;
        heldCo  <= carryout;
      end else begin
        chk("hold_sum", 32'(sum), 32'(heldSum));
        chk("hold_carryout", 32'(carryout), 32'(heldCo));
      end
    end
    prevOv <= (reset_n === 1'b1) && (out_valid === 1'b1);
  end

  task automatic runOp(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                       input logic [W-1:0] es, input logic eco, input logic eov,
                       input int hold, input bit keepValid, input bit noWait);
    exp_t x;
    if (!noWait) @(negedge clk);
    a = va; b = vb; carryin = vci; in_valid = 1'b1; out_ready = 1'b0;
    x.s = es; x.co = eco; x.ov = eov; x.acc = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (!keepValid) in_valid = 1'b0;
    a = ~va; b = ~vb; carryin = ~vci;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (keepValid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("out_valid_held", 32'(out_valid), 32'd1);
      if (keepValid) chk("in_ready_done", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b1; a = '0; b = '0; carryin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carryout", 32'(carryout), 32'd0);
    repeat (2) @(negedge clk);
    // First accept on the first rising edge after release.
    reset_n = 1'b1;
    runOp(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    runOp(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    runOp(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    runOp(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    runOp(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    runOp(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    runOp(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Result holds through IDLE; out_ready in IDLE has no effect.
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    chk("idle_hold_sum", 32'(sum), 32'h4C);
    chk("idle_hold_carryout", 32'(carryout), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-RUN after bit 3: the operation must be dropped.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; carryin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carryout", 32'(carryout), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * W) @(negedge clk);
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    runOp(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  operand A, sampled only on accept.
REQ-005 b  input  WIDTH  operand B, sampled only on accept.
REQ-006 carryin  input  1  initial carry, sampled only on accept.
REQ-007 in_valid  input  1  operands present.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 sum  output  WIDTH  result bits, LSB first assembly.
REQ-010 carryout  output  1  final carry out of bit WIDTH-1.
REQ-011 out_valid  output  1  sum/carryout valid.
REQ-012 out_ready  input  1  consumer takes result.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1: latch a, b, carryin into operand/carry registers, clear sum register and bit index, go to RUN.
REQ-016 In RUN, each cycle SHALL process one bit i (0 first): sum[i] = a[i] XOR b[i] XOR c; c <= majority(a[i], b[i], c); i <= i+1.
REQ-017 Per-bit arithmetic SHALL use one instance of the team's full-adder cell (sum, carry out, a, b, carry in), not a WIDTH-bit adder.
REQ-018 After bit WIDTH-1 is processed, FSM SHALL go to DONE; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-019 Bit index register SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap inside an operation.
REQ-020 In DONE, sum and carryout SHALL hold stable until out_ready=1; on that edge FSM SHALL return to IDLE.
REQ-021 In_valid in RUN or DONE SHALL be ignored; no operand capture; minimum accept-to-accept spacing is WIDTH+2 cycles.
REQ-022 sum and carryout SHALL be unchanged between operations (hold last result) while IDLE.
REQ-023 out_ready while not DONE SHALL have no effect.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, sum=0, carryout=0, carry register=0, bit index=0, in_ready=1, out_valid=0, regardless of clk.
REQ-025 Reset asserted in RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow deassertion.
REQ-026 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_OVERFLOW_EN, when defined, SHALL add output overflow (1 bit): two's-complement signed overflow = carry into bit WIDTH-1 XOR carryout, valid with out_valid, reset to 0, held like sum.
REQ-028 Without SERIAL_ADDER_OVERFLOW_EN the overflow port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 WIDTH=8, accept a=0x00 b=0x00 ci=0 -> 8 cycles later out_valid=1, sum=0x00, carryout=0.
REQ-030 a=0xFF b=0x01 ci=0 -> sum=0x00, carryout=1, out_valid exactly 8 cycles after accept edge.
REQ-031 a=0xA5 b=0x5A ci=1 -> sum=0x00, carryout=1; in_valid held high throughout -> in_ready=0 in RUN/DONE, no second capture.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> sum, carryout, out_valid stable; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 Assert reset_n=0 mid-RUN (after bit 3) -> outputs zero immediately; after release, no out_valid until a new accept.
REQ-034 With SERIAL_ADDER_OVERFLOW_EN: a=0x7F b=0x01 ci=0 -> sum=0x80, carryout=0, overflow=1; a=0xFF b=0x01 -> overflow=0.
